// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared widths, write-back request type and requester ids for the register-file write-back path.
package regfile_pkg;
    localparam int IDX_W    = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } requester_e;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Write-back request channels from the ALU and the load-return path into the controller.
interface regfile_wb_ctrl_if;
    import regfile_pkg::*;

    logic              alu_valid;
    logic [IDX_W-1:0]  alu_idx;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    modport master (
        output alu_valid, alu_idx, alu_data,
        input  alu_ready,
        output mem_valid, mem_idx, mem_data,
        input  mem_ready
    );

    modport slave (
        input  alu_valid, alu_idx, alu_data,
        output alu_ready,
        input  mem_valid, mem_idx, mem_data,
        output mem_ready
    );
endinterface

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; remembers the last winner and favours the other on contention.
// Latency: combinational grant; rr_last updates at the edge that consumes a grant.
// Backpressure: the losing requester sees no grant; no grants while rst_n is low.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    requester_e rr_last;

    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req == 2'b11) begin
                gnt = (rr_last == REQ_MEM) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= REQ_MEM;
        end else if (gnt[REQ_MEM]) begin
            rr_last <= REQ_MEM;
        end else if (gnt[REQ_ALU]) begin
            rr_last <= REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Shares the register-file write port between ALU and load return, and tracks busy registers.
// Latency: accepted request drives rf_we/index/data one cycle later; busy clears on that commit.
// Backpressure: at most one ready per cycle, round-robin on contention; readies low in reset.
module regfile_wb_ctrl
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_ctrl_if.slave    wb,
    input  logic                rsv_valid,
    input  logic [IDX_W-1:0]    rsv_idx,
    output logic                rsv_ok,
    input  logic [IDX_W-1:0]    chk_a_idx,
    input  logic [IDX_W-1:0]    chk_b_idx,
    output logic                hazard,
    output logic                rf_we,
    output logic [IDX_W-1:0]    rf_c_index,
    output logic [DATA_W-1:0]   rf_d_input,
    output logic [NUM_REGS-1:0] busy,
    output logic                err_unrsv
);

    logic [1:0]          req;
    logic [1:0]          gnt;
    wb_req_t             alu_req;
    wb_req_t             mem_req;
    wb_req_t             win;
    logic [NUM_REGS-1:0] busy_nxt;

    assign req     = {wb.mem_valid, wb.alu_valid};
    assign alu_req = {wb.alu_idx, wb.alu_data};
    assign mem_req = {wb.mem_idx, wb.mem_data};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign wb.alu_ready = gnt[REQ_ALU];
    assign wb.mem_ready = gnt[REQ_MEM];
    assign win          = gnt[REQ_MEM] ? mem_req : alu_req;

    // Checked against the current busy bits only, so a bit clearing this cycle still blocks.
    assign rsv_ok = rsv_valid & ~busy[rsv_idx];
    assign hazard = busy[chk_a_idx] | busy[chk_b_idx];

    always_comb begin
        busy_nxt = busy;
        if (rf_we) begin
            busy_nxt[rf_c_index] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_c_index <= '0;
            rf_d_input <= '0;
            busy       <= '0;
            err_unrsv  <= 1'b0;
        end else begin
            rf_we <= |gnt;
            if (|gnt) begin
                rf_c_index <= win.idx;
                rf_d_input <= win.data;
            end
            busy <= busy_nxt;
            if (rf_we && !busy[rf_c_index]) begin
                err_unrsv <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for the write-back controller with hand-computed expectations.
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rsv_valid;
    logic [IDX_W-1:0]    rsv_idx;
    logic                rsv_ok;
    logic [IDX_W-1:0]    chk_a_idx;
    logic [IDX_W-1:0]    chk_b_idx;
    logic                hazard;
    logic                rf_we;
    logic [IDX_W-1:0]    rf_c_index;
    logic [DATA_W-1:0]   rf_d_input;
    logic [NUM_REGS-1:0] busy;
    logic                err_unrsv;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_wb_ctrl_if wb_if ();

    regfile_wb_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb_if.slave),
        .rsv_valid  (rsv_valid),
        .rsv_idx    (rsv_idx),
        .rsv_ok     (rsv_ok),
        .chk_a_idx  (chk_a_idx),
        .chk_b_idx  (chk_b_idx),
        .hazard     (hazard),
        .rf_we      (rf_we),
        .rf_c_index (rf_c_index),
        .rf_d_input (rf_d_input),
        .busy       (busy),
        .err_unrsv  (err_unrsv)
    );

    always #5 clk = ~clk;

    // Contention scenario tables: request queues and expected commit order.
    logic [IDX_W-1:0]  alu_q_idx  [2] = '{3'd1, 3'd2};
    logic [DATA_W-1:0] alu_q_dat  [2] = '{16'hA001, 16'hA002};
    logic [IDX_W-1:0]  mem_q_idx  [2] = '{3'd3, 3'd4};
    logic [DATA_W-1:0] mem_q_dat  [2] = '{16'hC003, 16'hC004};
    logic              exp_ardy   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic              exp_mrdy   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [IDX_W-1:0]  exp_idx    [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
    logic [DATA_W-1:0] exp_dat    [4] = '{16'hA001, 16'hC003, 16'hA002, 16'hC004};
    logic [7:0]        exp_busy   [4] = '{8'h1E, 8'h1C, 8'h14, 8'h10};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_if.alu_valid = 1'b0;
        wb_if.alu_idx   = '0;
        wb_if.alu_data  = '0;
        wb_if.mem_valid = 1'b0;
        wb_if.mem_idx   = '0;
        wb_if.mem_data  = '0;
        rsv_valid       = 1'b0;
        rsv_idx         = '0;
        chk_a_idx       = '0;
        chk_b_idx       = '0;
    endtask

    initial begin
        int  ai;
        int  mi;
        logic ar;
        logic mr;

        // Reset with random activity on every input.
        rst_n           = 1'b0;
        wb_if.alu_valid = 1'b1;
        wb_if.alu_idx   = IDX_W'($urandom);
        wb_if.alu_data  = DATA_W'($urandom);
        wb_if.mem_valid = 1'b1;
        wb_if.mem_idx   = IDX_W'($urandom);
        wb_if.mem_data  = DATA_W'($urandom);
        rsv_valid       = 1'b1;
        rsv_idx         = IDX_W'($urandom);
        chk_a_idx       = IDX_W'($urandom);
        chk_b_idx       = IDX_W'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rf_we",   rf_we, 0);
        check_eq("rst_c_index", rf_c_index, 0);
        check_eq("rst_d_input", rf_d_input, 0);
        check_eq("rst_busy",    busy, 0);
        check_eq("rst_err",     err_unrsv, 0);
        check_eq("rst_alu_rdy", wb_if.alu_ready, 0);
        check_eq("rst_mem_rdy", wb_if.mem_ready, 0);
        idle();
        rst_n = 1'b1;

        // Single reserved write to r5.
        rsv_valid = 1'b1;
        rsv_idx   = 3'd5;
        chk_a_idx = 3'd5;
        #1;
        check_eq("sw_rsv_ok", rsv_ok, 1);
        check_eq("sw_haz_pre", hazard, 0);
        step();
        rsv_valid = 1'b0;
        check_eq("sw_busy_set", busy, 8'h20);
        check_eq("sw_haz_set", hazard, 1);
        wb_if.alu_valid = 1'b1;
        wb_if.alu_idx   = 3'd5;
        wb_if.alu_data  = 16'hBEEF;
        #1;
        check_eq("sw_alu_rdy", wb_if.alu_ready, 1);
        step();
        wb_if.alu_valid = 1'b0;
        check_eq("sw_we",      rf_we, 1);
        check_eq("sw_idx",     rf_c_index, 5);
        check_eq("sw_dat",     rf_d_input, 16'hBEEF);
        check_eq("sw_busy_wb", busy, 8'h20);
        check_eq("sw_haz_wb",  hazard, 1);
        step();
        check_eq("sw_we_off",   rf_we, 0);
        check_eq("sw_busy_clr", busy, 8'h00);
        check_eq("sw_haz_clr",  hazard, 0);
        check_eq("sw_idx_hold", rf_c_index, 5);
        check_eq("sw_dat_hold", rf_d_input, 16'hBEEF);
        check_eq("sw_err",      err_unrsv, 0);

        // Reset again so rr_last is back to MEM before the contention run.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();

        for (int r = 1; r <= 4; r++) begin
            rsv_valid = 1'b1;
            rsv_idx   = IDX_W'(r);
            #1;
            check_eq("ct_rsv_ok", rsv_ok, 1);
            step();
        end
        rsv_valid = 1'b0;
        check_eq("ct_busy_init", busy, 8'h1E);

        ai = 0;
        mi = 0;
        for (int k = 0; k < 4; k++) begin
            wb_if.alu_valid = (ai < 2);
            if (ai < 2) begin
                wb_if.alu_idx  = alu_q_idx[ai];
                wb_if.alu_data = alu_q_dat[ai];
            end
            wb_if.mem_valid = (mi < 2);
            if (mi < 2) begin
                wb_if.mem_idx  = mem_q_idx[mi];
                wb_if.mem_data = mem_q_dat[mi];
            end
            #1;
            ar = wb_if.alu_ready;
            mr = wb_if.mem_ready;
            check_eq($sformatf("ct%0d_alu_rdy", k), ar, exp_ardy[k]);
            check_eq($sformatf("ct%0d_mem_rdy", k), mr, exp_mrdy[k]);
            step();
            if (ar) ai++;
            if (mr) mi++;
            check_eq($sformatf("ct%0d_we", k),   rf_we, 1);
            check_eq($sformatf("ct%0d_idx", k),  rf_c_index, exp_idx[k]);
            check_eq($sformatf("ct%0d_dat", k),  rf_d_input, exp_dat[k]);
            check_eq($sformatf("ct%0d_busy", k), busy, exp_busy[k]);
        end
        wb_if.alu_valid = 1'b0;
        wb_if.mem_valid = 1'b0;
        check_eq("ct_alu_taken", ai, 2);
        check_eq("ct_mem_taken", mi, 2);
        step();
        check_eq("ct_we_off",   rf_we, 0);
        check_eq("ct_busy_end", busy, 8'h00);
        check_eq("ct_err",      err_unrsv, 0);

        // WAW stall on r2.
        rsv_valid = 1'b1;
        rsv_idx   = 3'd2;
        #1;
        check_eq("waw_rsv_first", rsv_ok, 1);
        step();
        check_eq("waw_busy", busy, 8'h04);
        check_eq("waw_rsv_blk", rsv_ok, 0);
        wb_if.alu_valid = 1'b1;
        wb_if.alu_idx   = 3'd2;
        wb_if.alu_data  = 16'h5555;
        #1;
        check_eq("waw_alu_rdy", wb_if.alu_ready, 1);
        step();
        wb_if.alu_valid = 1'b0;
        check_eq("waw_we", rf_we, 1);
        check_eq("waw_rsv_commit", rsv_ok, 0);
        step();
        check_eq("waw_busy_clr", busy, 8'h00);
        check_eq("waw_rsv_after", rsv_ok, 1);
        step();
        rsv_valid = 1'b0;
        check_eq("waw_busy_reset", busy, 8'h04);

        // Unreserved load return to r6.
        wb_if.mem_valid = 1'b1;
        wb_if.mem_idx   = 3'd6;
        wb_if.mem_data  = 16'h0001;
        #1;
        check_eq("ur_mem_rdy", wb_if.mem_ready, 1);
        step();
        wb_if.mem_valid = 1'b0;
        check_eq("ur_we",  rf_we, 1);
        check_eq("ur_idx", rf_c_index, 6);
        check_eq("ur_dat", rf_d_input, 16'h0001);
        check_eq("ur_err_pre", err_unrsv, 0);
        step();
        check_eq("ur_err_set", err_unrsv, 1);
        check_eq("ur_busy", busy, 8'h04);
        step();
        check_eq("ur_err_sticky", err_unrsv, 1);

        // Reset right after a grant: pending write and reservations are dropped.
        rsv_valid = 1'b1;
        rsv_idx   = 3'd7;
        step();
        rsv_valid = 1'b0;
        check_eq("rm_busy_pre", busy, 8'h84);
        wb_if.alu_valid = 1'b1;
        wb_if.alu_idx   = 3'd7;
        wb_if.alu_data  = 16'h7777;
        #1;
        check_eq("rm_alu_rdy", wb_if.alu_ready, 1);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rm_we",      rf_we, 0);
        check_eq("rm_busy",    busy, 0);
        check_eq("rm_err",     err_unrsv, 0);
        check_eq("rm_dat",     rf_d_input, 0);
        check_eq("rm_rdy_rst", wb_if.alu_ready, 0);
        step();
        check_eq("rm_we_hold", rf_we, 0);
        rst_n           = 1'b1;
        wb_if.alu_idx   = 3'd0;
        wb_if.mem_valid = 1'b1;
        wb_if.mem_idx   = 3'd0;
        #1;
        check_eq("rm_rr_alu", wb_if.alu_ready, 1);
        check_eq("rm_rr_mem", wb_if.mem_ready, 0);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
